board_frame_tx: RTL

Serial transmitter that reports the Connect-4 board to an external host/display, complementing the switch/button move-entry path.
- On a start pulse it snapshots the 16-cell occupancy and owner vectors plus the 2-bit game status.
- It then transmits a 7-byte frame over a UART-style 8N1 line.
- It sits beside the column selector and winner detector, clocked by the same divided game clock.

---
 rtl/board_frame_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/board_frame_tx.sv
// Connect-4 board reporter: snapshots the board on start and sends a 7-byte
// 8N1 frame (header, four row bytes, status, XOR checksum) on tx.
module board_frame_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hC4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] gameboard,
  input  logic [15:0] player_cells,
  input  logic [1:0]  game_status,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t          r_state, w_state_n;
  logic [BW-1:0]   r_baud, w_baud_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [2:0]      r_idx, w_idx_n;
  logic            r_tx, w_tx_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic [3:0][7:0] r_rows;
  logic [1:0]      r_status;

  logic [3:0][7:0] w_rows_in;
  logic [7:0]      w_cksum, w_cur;
  logic [2:0]      w_nbit;
  logic            w_last_baud, w_load;

  // Two-bit cell codes packed four per row byte, cell 4r in bits [1:0].
  always_comb begin
    w_rows_in = '0;
    for (int i = 0; i < 16; i++)
      w_rows_in[i/4][2*(i%4) +: 2] = gameboard[i] ? (player_cells[i] ? 2'b10 : 2'b01) : 2'b00;
  end

  assign w_cksum     = r_rows[0] ^ r_rows[1] ^ r_rows[2] ^ r_rows[3] ^ {6'b0, r_status};
  assign w_last_baud = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_nbit      = r_bit + 3'd1;
  assign w_load      = (r_state == IDLE) && start;

  always_comb begin
    case (r_idx)
      3'd0:    w_cur = HEADER;
      3'd1:    w_cur = r_rows[0];
      3'd2:    w_cur = r_rows[1];
      3'd3:    w_cur = r_rows[2];
      3'd4:    w_cur = r_rows[3];
      3'd5:    w_cur = {6'b0, r_status};
      default: w_cur = w_cksum;
    endcase
  end

  // Outputs are computed one cycle ahead so tx/busy/done come straight from flops.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_idx_n   = r_idx;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
        if (start) begin
          w_state_n = START_BIT;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_idx_n   = '0;
          w_tx_n    = 1'b0;
          w_busy_n  = 1'b1;
        end
      end
      START_BIT: begin
        w_baud_n = r_baud + 1'b1;
        if (w_last_baud) begin
          w_baud_n  = '0;
          w_state_n = DATA_BITS;
          w_tx_n    = w_cur[0];
        end
      end
      DATA_BITS: begin
        w_baud_n = r_baud + 1'b1;
        if (w_last_baud) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_bit_n   = '0;
            w_state_n = STOP_BIT;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n = w_nbit;
            w_tx_n  = w_cur[w_nbit];
          end
        end
      end
      STOP_BIT: begin
        w_baud_n = r_baud + 1'b1;
        if (w_last_baud) begin
          w_baud_n = '0;
          if (r_idx < 3'd6) begin
            w_idx_n   = r_idx + 3'd1;
            w_state_n = START_BIT;
            w_tx_n    = 1'b0;
          end else begin
            w_idx_n   = '0;
            w_state_n = IDLE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_idx   <= w_idx_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows   <= '0;
      r_status <= '0;
    end else if (w_load) begin
      r_rows   <= w_rows_in;
      r_status <= game_status;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;
endmodule
